seven_seg_scanner: RTL
======================

# seven_seg_scanner

Parametrised multiplexed seven-segment display controller for the board top level. It time-multiplexes `NUM_DIGITS` hex digits from one of `NUM_CHANNELS` 32-bit-class debug sources (display register, program counter, flags, ...). The active channel is chosen by a debounced push button, and the block adds leading-zero blanking and PWM brightness control. It sits between the CPU debug outputs and the board's SEG/AN/DP pins.

## Interface
- `NUM_DIGITS`, 8, number of digits/anodes (1..8)
- `NUM_CHANNELS`, 4, number of selectable sources (1..16)
- `CLK_HZ`, 100_000_000, input clock frequency
- `REFRESH_HZ`, 1000, per-digit slot rate; `DIGIT_CYCLES = CLK_HZ/REFRESH_HZ` (truncated), must be ≥16
- `DEBOUNCE_CYCLES`, 1_000_000, stable cycles required to accept a button level
- `clk` in 1: system clock
- `rstN` in 1: asynchronous, active-low reset
- `channels` in NUM_CHANNELS*4*NUM_DIGITS: channel c occupies bits [c*4*NUM_DIGITS +: 4*NUM_DIGITS]; nibble d is digit d (digit 0 rightmost)
- `btnNext` in 1: raw asynchronous push button, active-high
- `brightness` in 4: duty level, 0 = dark, 15 = 15/16 on
- `blankLeadingZeros` in 1: enables leading-zero suppression
- `seg` out 7: cathodes {g..a}, active-low
- `an` out NUM_DIGITS: anodes, active-low, at most one low
- `dp` out 1: decimal point, active-low
- `activeChannel` out max(1,$clog2(NUM_CHANNELS)): current selected source

## Operation
- Slot counter counts 0..DIGIT_CYCLES-1. At wrap, the digit index advances d → d+1, and NUM_DIGITS-1 wraps to 0.
- Frame start is defined as the digit index becoming 0. At frame start the selected channel's value is latched into a snapshot register. All digits of one frame come from a single snapshot, so there is no tearing.
- Each slot is divided into 16 sub-slots of `SUB = DIGIT_CYCLES/16` cycles. The anode is driven low only while sub-slot index < `brightness`. The remaining cycles of the slot beyond 16*SUB are dark.
- Hex decode of 0–F uses the standard a–g patterns (e.g. 0 = 7'b1000000, F = 7'b0001110).
- Leading-zero blanking applies when `blankLeadingZeros`=1:
  - Digit d is blanked if it and every higher digit in the snapshot are zero.
  - Digit 0 is never blanked.
  - Blanked means `an` for that digit stays high.
- `dp` is low only during digit slot d == activeChannel, gated by the same duty as `an`. This marks the channel number. If activeChannel ≥ NUM_DIGITS, dp is never lit.
- Button path:
  - 2-flop synchroniser, then a stability counter.
  - The debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A rising edge of the debounced level increments activeChannel, wrapping NUM_CHANNELS-1 → 0.
  - When NUM_CHANNELS=1, activeChannel is held at 0.

## Timing
- Reset (rstN low, asynchronous): seg=7'h7F, an=all ones, dp=1, activeChannel=0, digit index 0, counters 0, snapshot 0, debounced level 0.
- The first frame starts on the first clock after rstN deasserts, so the snapshot is latched on that clock.
- Outputs are registered. seg/an/dp update together, one cycle after the slot or sub-slot counter state that selects them.
- Button latency: activeChannel changes 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after a clean rising edge on btnNext.
- A channel change becomes visible at the next frame start, never mid-frame.
- Brightness is sampled every cycle. A change mid-slot affects only the remaining sub-slots.
- Reset asserted mid-frame or mid-debounce blanks the outputs immediately and discards any pending button edge.
- If a channel change and a frame start occur in the same cycle, the snapshot uses the new channel.

## Configuration
- `SEVEN_SEG_BRIGHTNESS_EN` defined: PWM behaviour as above.
- `SEVEN_SEG_BRIGHTNESS_EN` not defined:
  - `brightness` is ignored and the sub-slot logic is removed.
  - The anode and dp are on for the whole slot, except blanked digits.
  - 0 still does not darken the display.

## Test plan
All scenarios use NUM_DIGITS=4, NUM_CHANNELS=3, CLK_HZ=1600, REFRESH_HZ=100 (DIGIT_CYCLES=16, SUB=1), DEBOUNCE_CYCLES=4.
- Reset scan: hold rstN low, then release with channel0=16'h12AF, brightness=15, blanking off.
  - Required: outputs all high during reset.
  - Required: then an=4'b1110 with seg for F, after 16 cycles an=4'b1101 with seg for A, and so on through digit 3.
- Blanking: channel0=16'h0030, blankLeadingZeros=1.
  - Required: digits 3 and 2 keep an high.
  - Required: digit 1 shows 3 and digit 0 shows 0.
  - Required: channel0=0 shows only digit 0 as 0.
- Brightness: brightness=4.
  - Required: the active anode is low for exactly 4 of each 16 cycles.
  - Required: brightness=0 gives an all high.
  - Required: without the macro, 16 of 16 cycles low.
- Debounce:
  - Required: btnNext pulses of 3 cycles leave activeChannel=0.
  - Required: a clean press of ≥7 cycles gives activeChannel=1 exactly 7 cycles after the edge.
  - Required: three presses wrap activeChannel back to 0.
- Frame atomicity: change the channel during digit slot 2 with channel1=16'hBEEF.
  - Required: the current frame finishes with channel0 digits.
  - Required: the next frame shows F,E,E,B, with dp lit on digit 1.
- Mid-frame reset: assert rstN during digit slot 2.
  - Required: the same cycle gives seg=7'h7F, an=4'hF, activeChannel=0.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed hex display with channel select, blanking.
// Optional PWM dimming is enabled by defining SEVEN_SEG_BRIGHTNESS_EN.
module seven_seg_scanner #(
  parameter int NUM_DIGITS      = 8,
  parameter int NUM_CHANNELS    = 4,
  parameter int CLK_HZ          = 100_000_000,
  parameter int REFRESH_HZ      = 1000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rstN,
  input  logic [NUM_CHANNELS*4*NUM_DIGITS-1:0] channels,
  input  logic                                 btnNext,
  input  logic [3:0]                           brightness,
  input  logic                                 blankLeadingZeros,
  output logic [6:0]                           seg,
  output logic [NUM_DIGITS-1:0]                an,
  output logic                                 dp,
  output logic [CH_W-1:0]                      activeChannel
);

  localparam int DIGIT_CYCLES = CLK_HZ / REFRESH_HZ;
  localparam int SLOT_W = $clog2(DIGIT_CYCLES);
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W  = 4 * NUM_DIGITS;
  localparam int DEB_W  =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DIG_W-1:0]  digit_q, digit_d;
  logic [VAL_W-1:0]  snap_q, snap_d, disp;
  logic              started_q, started_d;
  logic [6:0]        seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic              dp_q, dp_d;
  logic              sync1_q, sync2_q;
  logic              deb_q, deb_d, deb_prev_q;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  logic slot_wrap, digit_last, frame_start;
  logic lit, blanked, on, dp_hit, zero_run;
  logic [NUM_DIGITS-1:0] lz;
  logic [3:0] nib;
  int unsigned sel_base;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    unique case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Debounce the synchronised button and step the channel on each press.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    ch_d = ch_q;
    if (deb_q && !deb_prev_q) begin
      if (ch_q == CH_W'(NUM_CHANNELS - 1)) begin
        ch_d = '0;
      end else begin
        ch_d = ch_q + 1'b1;
      end
    end
  end

  // Slot/digit scan; the very first clock out of reset opens a frame.
  always_comb begin
    slot_wrap   = (slot_q == SLOT_W'(DIGIT_CYCLES - 1));
    digit_last  = (digit_q == DIG_W'(NUM_DIGITS - 1));
    slot_d      = slot_wrap ? '0 : slot_q + 1'b1;
    digit_d     = digit_q;
    if (slot_wrap) begin
      digit_d = digit_last ? '0 : digit_q + 1'b1;
    end
    frame_start = !started_q || (slot_wrap && digit_last);
    started_d   = 1'b1;
    sel_base    = 32'(ch_d) * VAL_W;
    snap_d      = frame_start ? channels[sel_base +: VAL_W] : snap_q;
    disp        = started_q ? snap_q : snap_d;
  end

`ifdef SEVEN_SEG_BRIGHTNESS_EN
  localparam int SUB   = DIGIT_CYCLES / 16;
  localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;

  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [4:0]       sub_idx_q, sub_idx_d;

  // Sub-slot index saturates at 16, so the slot tail stays dark.
  always_comb begin
    sub_cnt_d = sub_cnt_q;
    sub_idx_d = sub_idx_q;
    if (slot_wrap) begin
      sub_cnt_d = '0;
      sub_idx_d = '0;
    end else if (sub_idx_q != 5'd16) begin
      if (sub_cnt_q == SUB_W'(SUB - 1)) begin
        sub_cnt_d = '0;
        sub_idx_d = sub_idx_q + 5'd1;
      end else begin
        sub_cnt_d = sub_cnt_q + 1'b1;
      end
    end
    lit = (sub_idx_q < {1'b0, brightness});
  end

  // Sub-slot counters.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sub_cnt_q <= '0;
      sub_idx_q <= '0;
    end else begin
      sub_cnt_q <= sub_cnt_d;
      sub_idx_q <= sub_idx_d;
    end
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign lit = 1'b1;
`endif

  // Leading-zero mask, digit select and next output pattern.
  always_comb begin
    zero_run = 1'b1;
    lz       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp[4*i +: 4] == 4'h0);
      lz[i]    = zero_run && (i != 0);
    end
    nib     = disp[4*digit_q +: 4];
    blanked = blankLeadingZeros && lz[digit_q];
    on      = lit && !blanked;
    dp_hit  = (32'(digit_q) == 32'(ch_q));
    seg_d   = on ? hex7(nib) : 7'h7F;
    an_d    = on ? ~(NUM_DIGITS'(1) << digit_q) : '1;
    dp_d    = !(lit && dp_hit);
  end

  // State and registered pin drivers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      slot_q     <= '0;
      digit_q    <= '0;
      snap_q     <= '0;
      started_q  <= 1'b0;
      seg_q      <= 7'h7F;
      an_q       <= '1;
      dp_q       <= 1'b1;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      ch_q       <= '0;
    end else begin
      slot_q     <= slot_d;
      digit_q    <= digit_d;
      snap_q     <= snap_d;
      started_q  <= started_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
      sync1_q    <= btnNext;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      ch_q       <= ch_d;
    end
  end

  assign seg           = seg_q;
  assign an            = an_q;
  assign dp            = dp_q;
  assign activeChannel = ch_q;

endmodule
